// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings and decode helpers for the load/store unit.
//               Size codes, FSM state type, misalignment/illegal-size decode.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Access size encodings as presented on size_i
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Halfwords must sit on an even byte, words on a 4-byte boundary
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lo);
        logic r;
        r = 1'b0;
        case (size)
            SZ_H, SZ_HU: r = lo[0];
            SZ_W:        r = (lo != 2'b00);
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

    // Any code outside the five defined sizes
    function automatic logic is_illegal(input logic [2:0] size);
        logic r;
        r = 1'b1;
        case (size)
            SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: r = 1'b0;
            default:                        r = 1'b1;
        endcase
        return r;
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane steering for the load/store unit.
//               Extracts and extends the addressed lane of a RAM word for
//               loads, and merges sub-word store data into a read word.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rword,   // word read from RAM (load path)
    input  logic [31:0] rbuf,    // buffered word for read-modify-write
    input  logic [31:0] wdata,   // right-aligned store data
    input  logic [2:0]  size,    // access size code
    input  logic [1:0]  lo,      // low byte-address bits
    output logic [31:0] ldata,   // extended load result
    output logic [31:0] mdata    // merged store word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed lane and sign/zero extend it
    always_comb begin
        w_byte = rword[{lo, 3'b000} +: 8];
        w_half = lo[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_B:    ldata = {{24{w_byte[7]}}, w_byte};
            SZ_BU:   ldata = {24'h000000, w_byte};
            SZ_H:    ldata = {{16{w_half[15]}}, w_half};
            SZ_HU:   ldata = {16'h0000, w_half};
            default: ldata = rword;
        endcase
    end

    // Replace the addressed lane(s) of the buffered word; words pass straight through
    always_comb begin
        mdata = rbuf;
        case (size)
            SZ_B, SZ_BU: mdata[{lo, 3'b000} +: 8] = wdata[7:0];
            SZ_H, SZ_HU: begin
                if (lo[1]) mdata[31:16] = wdata[15:0];
                else       mdata[15:0]  = wdata[15:0];
            end
            default:     mdata = wdata;
        endcase
    end

endmodule : lsu_lane_align
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store sequencer between the core memory stage and a
//               word-addressed RAM (combinational read, synchronous write).
//               Sub-word stores use read-modify-write; the core is stalled
//               while an access is in flight.
//               Build option: LSU_MISALIGN_CHECK_EN enables misaligned and
//               illegal-size detection reported on err_o.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o,
    output logic              stall_o,
    output logic              err_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [WIDTH-1:0]  mem_wd_o,
    input  logic [WIDTH-1:0]  mem_rd_i
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;

    logic [WIDTH-1:0]  r_rbuf;
    logic [WIDTH-1:0]  r_rdata;
    logic              r_err;

    // Access attributes captured when the access leaves IDLE
    logic              r_we;
    logic [2:0]        r_size;
    logic [1:0]        r_lo;
    logic [WIDTH-1:0]  r_wdata;

    logic [2:0]        w_size_eff;
    logic              w_err_req;
    logic [WIDTH-1:0]  w_ldata;
    logic [WIDTH-1:0]  w_mdata;

`ifdef LSU_MISALIGN_CHECK_EN
    // Misaligned or undefined sizes are answered with an error and no RAM access
    always_comb begin
        w_size_eff = size_i;
        w_err_req  = is_misaligned(size_i, addr_i[1:0]) | is_illegal(size_i);
    end
`else
    // No checking: undefined sizes behave as word accesses, low bits only steer lanes
    always_comb begin
        w_size_eff = is_illegal(size_i) ? SZ_W : size_i;
        w_err_req  = 1'b0;
    end
`endif

    lsu_lane_align u_align (
        .rword (mem_rd_i),
        .rbuf  (r_rbuf),
        .wdata (r_wdata),
        .size  (r_size),
        .lo    (r_lo),
        .ldata (w_ldata),
        .mdata (w_mdata)
    );

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    if (w_err_req)                      w_next = RESP;
                    else if (we_i && w_size_eff == SZ_W) w_next = WR;
                    else                                 w_next = RD;
                end
            end
            RD:      w_next = r_we ? WR : RESP;
            WR:      w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, read buffer, captured attributes and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rbuf  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_size  <= SZ_B;
            r_lo    <= 2'b00;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        r_we    <= we_i;
                        r_size  <= w_size_eff;
                        r_lo    <= addr_i[1:0];
                        r_wdata <= wdata_i;
                        r_err   <= w_err_req;
                    end
                end
                RD: begin
                    r_rbuf <= mem_rd_i;
                    if (!r_we) r_rdata <= w_ldata;
                end
                default: ;
            endcase
        end
    end

    // Core- and RAM-facing outputs
    always_comb begin
        stall_o  = req_i & (r_state != RESP);
        mem_a_o  = {addr_i[ADDR_W-1:2], 2'b00};
        mem_we_o = (r_state == WR);
        mem_wd_o = w_mdata;
        rdata_o  = r_rdata;
        err_o    = r_err;
    end

endmodule : lsu_ctrl
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Directed self-checking bench for lsu_ctrl with a behavioural
//               word RAM (combinational read, synchronous write).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [2:0]  size_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        err_o;
    logic        mem_we_o;
    logic [31:0] mem_a_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;

    int          n_checks;
    int          n_fails;

    logic [31:0] ram [0:63];
    logic        ram_init;
    int          we_cnt;
    logic [31:0] last_wd;

    int          t_stalls;
    logic [31:0] t_rdata;
    logic        t_err;
    logic [31:0] t_ma;
    int          we0;

    lsu_ctrl #(.WIDTH(32), .ADDR_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .we_i     (we_i),
        .size_i   (size_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .stall_o  (stall_o),
        .err_o    (err_o),
        .mem_we_o (mem_we_o),
        .mem_a_o  (mem_a_o),
        .mem_wd_o (mem_wd_o),
        .mem_rd_i (mem_rd_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM read port: out-of-range reads return zero
    always_comb begin
        mem_rd_i = (mem_a_o < 32'd256) ? ram[mem_a_o[7:2]] : 32'h0;
    end

    // RAM write port plus write monitor
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
            we_cnt  <= 0;
            last_wd <= 32'h0;
        end else if (mem_we_o) begin
            if (mem_a_o < 32'd256) ram[mem_a_o[7:2]] <= mem_wd_o;
            we_cnt  <= we_cnt + 1;
            last_wd <= mem_wd_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one access, count stalled cycles up to the done cycle
    task automatic access(input logic w, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input bit hold, input bit b2b);
        int n;
        req_i   = 1'b1;
        we_i    = w;
        size_i  = sz;
        addr_i  = a;
        wdata_i = d;
        n = 0;
        if (b2b) @(negedge clk);
        #1;
        t_ma = mem_a_o;
        while (stall_o === 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
            #1;
        end
        t_stalls = n;
        t_rdata  = rdata_o;
        t_err    = err_o;
        if (!hold) req_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        ram_init = 1'b1;
        req_i    = 1'b0;
        we_i     = 1'b0;
        size_i   = SZ_W;
        addr_i   = 32'h0;
        wdata_i  = 32'h0;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        ram_init = 1'b0;
        #1;

        // Reset state
        check("rst_stall", {31'h0, stall_o}, 32'h0);
        check("rst_we",    {31'h0, mem_we_o}, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_err",   {31'h0, err_o}, 32'h0);

        // 1: word store then word load
        @(negedge clk);
        we0 = we_cnt;
        access(1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
        check("sw_stalls", t_stalls, 2);
        check("sw_wecnt",  we_cnt - we0, 1);
        check("sw_ram",    ram[4], 32'hDEADBEEF);
        @(negedge clk);
        access(1'b0, SZ_W, 32'h10, 32'h0, 1'b0, 1'b0);
        check("lw_stalls", t_stalls, 2);
        check("lw_rdata",  t_rdata, 32'hDEADBEEF);
        check("lw_err",    {31'h0, t_err}, 32'h0);

        // 2: sub-word read-modify-write
        @(negedge clk);
        access(1'b1, SZ_W, 32'h20, 32'h11223344, 1'b0, 1'b0);
        @(negedge clk);
        we0 = we_cnt;
        access(1'b1, SZ_B, 32'h21, 32'hFFFFFFAA, 1'b0, 1'b0);
        check("sb_stalls", t_stalls, 3);
        check("sb_wd",     last_wd, 32'h1122AA44);
        check("sb_wecnt",  we_cnt - we0, 1);
        @(negedge clk);
        access(1'b0, SZ_B, 32'h21, 32'h0, 1'b0, 1'b0);
        check("lb_rdata",  t_rdata, 32'hFFFFFFAA);
        @(negedge clk);
        access(1'b0, SZ_BU, 32'h21, 32'h0, 1'b0, 1'b0);
        check("lbu_rdata", t_rdata, 32'h000000AA);
        @(negedge clk);
        access(1'b0, SZ_B, 32'h23, 32'h0, 1'b0, 1'b0);
        check("lb_pos",    t_rdata, 32'h00000011);

        // 3: halfword store into the upper half, then signed/unsigned loads
        @(negedge clk);
        access(1'b1, SZ_H, 32'h32, 32'h00008001, 1'b0, 1'b0);
        check("sh_stalls", t_stalls, 3);
        check("sh_ram",    ram[12], 32'h80010000);
        @(negedge clk);
        access(1'b0, SZ_H, 32'h32, 32'h0, 1'b0, 1'b0);
        check("lh_rdata",  t_rdata, 32'hFFFF8001);
        @(negedge clk);
        access(1'b0, SZ_HU, 32'h32, 32'h0, 1'b0, 1'b0);
        check("lhu_rdata", t_rdata, 32'h00008001);

        // 4: misaligned word load and illegal size
        @(negedge clk);
        we0 = we_cnt;
        access(1'b0, SZ_W, 32'h13, 32'h0, 1'b0, 1'b0);
        check("mis_addr",  t_ma, 32'h10);
        check("mis_wecnt", we_cnt - we0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        check("mis_stalls", t_stalls, 1);
        check("mis_err",    {31'h0, t_err}, 32'h1);
`else
        check("mis_stalls", t_stalls, 2);
        check("mis_err",    {31'h0, t_err}, 32'h0);
        check("mis_rdata",  t_rdata, 32'hDEADBEEF);
`endif
        @(negedge clk);
        access(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
        check("ill_err",    {31'h0, t_err}, 32'h1);
        check("ill_stalls", t_stalls, 1);
`else
        check("ill_err",    {31'h0, t_err}, 32'h0);
        check("ill_rdata",  t_rdata, 32'hDEADBEEF);
`endif
        @(negedge clk);
        access(1'b0, SZ_H, 32'h30, 32'h0, 1'b0, 1'b0);
        check("err_clear", {31'h0, t_err}, 32'h0);
        check("lh_low",    t_rdata, 32'h00000000);

        // 5: reset while a byte store is in its read phase
        @(negedge clk);
        access(1'b1, SZ_W, 32'h44, 32'h12345678, 1'b0, 1'b0);
        @(negedge clk);
        access(1'b0, SZ_W, 32'h44, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        we0     = we_cnt;
        req_i   = 1'b1;
        we_i    = 1'b1;
        size_i  = SZ_B;
        addr_i  = 32'h44;
        wdata_i = 32'h55;
        @(negedge clk);
        rst   = 1'b1;
        req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rr_we",    {31'h0, mem_we_o}, 32'h0);
        check("rr_rdata", rdata_o, 32'h0);
        check("rr_err",   {31'h0, err_o}, 32'h0);
        check("rr_stall", {31'h0, stall_o}, 32'h0);
        repeat (3) @(negedge clk);
        check("rr_wecnt", we_cnt - we0, 0);
        check("rr_ram",   ram[17], 32'h12345678);
        access(1'b0, SZ_W, 32'h44, 32'h0, 1'b0, 1'b0);
        check("rr_lw_stalls", t_stalls, 2);
        check("rr_lw_rdata",  t_rdata, 32'h12345678);

        // 6: back-to-back byte store then word load with req held
        @(negedge clk);
        access(1'b1, SZ_B, 32'h40, 32'h0000005A, 1'b1, 1'b0);
        check("b2b_sb_stalls", t_stalls, 3);
        access(1'b0, SZ_W, 32'h40, 32'h0, 1'b0, 1'b1);
        check("b2b_lw_stalls", t_stalls, 2);
        check("b2b_lw_rdata",  t_rdata, 32'h0000005A);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_lsu_ctrl
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store sequencer between the core's memory stage and the word-addressed data RAM. The RAM has a combinational read and a synchronous, whole-word write. The block converts byte, halfword and word loads/stores into RAM word accesses, using read-modify-write for sub-word stores. It stalls the core while an access is in flight.

Parameters:
WIDTH, 32, data width; fixed at 32 (4 byte lanes).
ADDR_W, 32, byte address width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_i  in  1  core access request; held stable by the core while stall_o=1
we_i  in  1  1=store, 0=load
size_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
addr_i  in  ADDR_W  byte address
wdata_i  in  WIDTH  store data, right-aligned
rdata_o  out  WIDTH  load result, extended
stall_o  out  1  core must hold
err_o  out  1  misaligned access, valid with done
mem_we_o  out  1  RAM write enable
mem_a_o  out  ADDR_W  RAM byte address, low 2 bits forced to 00
mem_wd_o  out  WIDTH  RAM write data
mem_rd_i  in  WIDTH  RAM read data (combinational)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous, active-high.
- FSM states: IDLE, RD, WR, RESP.
- Reset (rst=1 at posedge): state=IDLE; rbuf, rdata_o, err_o cleared to 0; mem_we_o=0.
- A reset mid-access abandons the access. No write occurs after the reset edge.
- Outputs:
  - stall_o = req_i & (state!=RESP), combinational.
  - mem_a_o = {addr_i[ADDR_W-1:2],2'b00} in all states.
  - mem_we_o=1 only in WR.
- IDLE transitions on req_i:
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0) -> RESP, err_o=1, no RAM access.
  - Load, or B/H store -> RD.
  - W store -> WR, with mem_wd_o=wdata_i.
  - Illegal size_i (011, 11x) -> RESP, err_o=1.
- RD: rbuf <= mem_rd_i.
  - Load -> RESP, with rdata_o <= extracted lane:
    - byte selected by addr[1:0], halfword by addr[1];
    - sign-extended for B/H, zero-extended for BU/HU.
  - Store -> WR.
- WR: mem_wd_o = rbuf with the addressed lane(s) replaced by wdata_i[7:0] or [15:0]; word stores use wdata_i directly. Next state RESP.
- RESP: stall_o=0 (done). rdata_o and err_o hold until the next access leaves IDLE. Next state IDLE. err_o is cleared when a new access starts.
- Latency (cycles stalled):
  - load 2;
  - word store 2;
  - sub-word store 3;
  - misaligned/illegal 1.
- Back-to-back requests: a request held high after RESP starts a new access from IDLE in the following cycle.
- req_i dropping mid-access is a protocol violation. The FSM still completes, including the write.
- Out-of-range addresses are not checked here; the RAM returns 0 for reads.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: misaligned/illegal detection as above, with err_o.
- Undefined:
  - err_o is tied to 0.
  - Misaligned H/W accesses are treated as aligned: low address bits are ignored for lane selection (H uses addr[1], W uses none).
  - Illegal size_i decodes as W.

Decomposition:
- lsu_pkg:
  - size encodings SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101;
  - state enum lsu_state_t {IDLE,RD,WR,RESP};
  - function is_misaligned(size, addr[1:0]).
- Sub-module lsu_lane_align (combinational): load extract+extend, and store merge(rbuf, wdata, size, addr[1:0]).

Test Plan:
1. Word store then load: SW 0xDEADBEEF @0x10, then LW @0x10.
   - Store: mem_we_o=1 for exactly one cycle; stall 2 cycles.
   - Load: rdata_o=0xDEADBEEF after 2 stall cycles.
2. Sub-word RMW: RAM[0x20]=0x11223344; SB 0xAA @0x21.
   - mem_wd_o=0x1122AA44 in WR; 3 stall cycles.
   - Then LB @0x21 -> 0xFFFFFFAA; LBU @0x21 -> 0x000000AA.
3. Halfword: SH 0x8001 @0x32 over RAM=0; then LH @0x32.
   - RAM word = 0x80010000.
   - LH -> 0xFFFF8001; LHU -> 0x00008001.
4. Misaligned, with LSU_MISALIGN_CHECK_EN: LW @0x13.
   - err_o=1; 1 stall cycle; no mem_we_o.
   - Without the macro: reads word 0x10, err_o=0.
5. Reset mid-RMW: assert rst during RD of an SB.
   - state=IDLE; mem_we_o never asserted; outputs = 0.
6. Back-to-back: SB @0x40 with req held, then LW @0x40 presented after RESP.
   - Second access starts the next cycle.
   - rdata_o reflects the merged byte.
